// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, default
// timing parameters and the clog2 helper used for width checks.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } sched_state_t;

    localparam int unsigned DEF_BUSY_TIMEOUT = 16;
    localparam int unsigned DEF_LOCK_HOLD    = 20000;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = (n > 0) ? n - 1 : 0; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter side signals of the UART transmit scheduler.
// The scheduler uses the slave modport; sources and the transmitter use master.
interface uart_tx_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [ID_W-1:0]      active_id;
    logic                 locked;
    logic                 timeout_err;

    modport master (
        output req, req_data, req_last, tx_busy,
        input  req_ack, tx_start, tx_data, active_id, locked, timeout_err
    );

    modport slave (
        input  req, req_data, req_last, tx_busy,
        output req_ack, tx_start, tx_data, active_id, locked, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first eligible request at or after
// (pointer + 1) mod NUM_REQ. The pointer register lives in the scheduler.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [ID_W-1:0]    pointer,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               valid
);
    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    idx;

    always_comb begin
        eligible = request & mask;
        grant    = '0;
        id       = '0;
        valid    = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(pointer) + k) % NUM_REQ);
            if (!valid && eligible[idx]) begin
                valid      = 1'b1;
                id         = idx;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART transmitter between NUM_REQ byte streams with
// round-robin arbitration, per-message locking and a busy-rise timeout.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter int unsigned LOCK_HOLD    = DEF_LOCK_HOLD
) (
    input  logic                Clk_100M,
    input  logic                Rst,
    uart_tx_scheduler_if.slave  bus
);
    localparam int unsigned TMO_W  = clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned HOLD_W = clog2(LOCK_HOLD + 1);

    if (ID_W != clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || BUSY_TIMEOUT < 2) begin : g_param_check
        $error("uart_tx_scheduler: unsupported parameter combination");
    end

    sched_state_t       state;
    logic [ID_W-1:0]    rr;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [HOLD_W-1:0]  hold_cnt;

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_valid;

    assign mask = bus.locked ? (NUM_REQ'(1) << bus.active_id) : '1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .request (bus.req),
        .pointer (rr),
        .mask    (mask),
        .grant   (grant),
        .id      (grant_id),
        .valid   (grant_valid)
    );

    // Outputs are registered, so each state's actions are committed on the
    // edge entering it: ack/latch on IDLE->LOAD, start pulse on LOAD->START.
    always_ff @(posedge Clk_100M or posedge Rst) begin
        if (Rst) begin
            state           <= S_IDLE;
            bus.req_ack     <= '0;
            bus.tx_start    <= 1'b0;
            bus.tx_data     <= '0;
            bus.active_id   <= '0;
            bus.locked      <= 1'b0;
            bus.timeout_err <= 1'b0;
            rr              <= '0;
            tmo_cnt         <= '0;
            hold_cnt        <= '0;
        end else begin
            bus.req_ack     <= '0;
            bus.tx_start    <= 1'b0;
            bus.timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!bus.tx_busy) begin
                        if (grant_valid) begin
                            state         <= S_LOAD;
                            bus.req_ack   <= grant;
                            bus.tx_data   <= bus.req_data[{grant_id, 3'b000} +: 8];
                            bus.active_id <= grant_id;
                            bus.locked    <= !bus.req_last[grant_id];
                            rr            <= grant_id;
                            hold_cnt      <= '0;
                        end else if (bus.locked) begin
                            if (hold_cnt == HOLD_W'(LOCK_HOLD - 1)) begin
                                bus.locked <= 1'b0;
                                hold_cnt   <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    bus.tx_start <= 1'b1;
                    state        <= S_START;
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    // tmo_cnt lags the cycles since start by one, so the pulse
                    // lands exactly BUSY_TIMEOUT cycles after tx_start.
                    if (bus.tx_busy) begin
                        state <= S_WAIT_LO;
                    end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 2)) begin
                        bus.timeout_err <= 1'b1;
                        bus.locked      <= 1'b0;
                        hold_cnt        <= '0;
                        state           <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of single-grant vectors plus
// hand sequences for timeout, lock stall and asynchronous reset.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned ID_W         = 2;
    localparam int unsigned BUSY_TIMEOUT = 16;
    localparam int unsigned LOCK_HOLD    = 40;
    localparam int          TX_LEN       = 10;
    localparam int          NV           = 10;

    logic Clk_100M = 1'b0;
    logic Rst;
    bit   tx_en;
    int   tx_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .ID_W         (ID_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .LOCK_HOLD    (LOCK_HOLD)
    ) dut (
        .Clk_100M (Clk_100M),
        .Rst      (Rst),
        .bus      (bus)
    );

    always #5 Clk_100M = ~Clk_100M;

    // Transmitter model: busy rises one cycle after tx_start, held TX_LEN cycles.
    always @(posedge Clk_100M) begin
        #1;
        if (Rst) begin
            tx_cnt      = 0;
            bus.tx_busy = 1'b0;
        end else if (tx_cnt > 0) begin
            tx_cnt++;
            if (tx_cnt == TX_LEN + 2) tx_cnt = 0;
            bus.tx_busy = (tx_cnt >= 2);
        end else if (bus.tx_start && tx_en) begin
            tx_cnt = 1;
        end
    end

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [3:0]  last;
        logic [31:0] data;
        int          exp_id;
        logic [7:0]  exp_data;
        logic        exp_locked;
        int          exp_lat;
    } vec_t;

    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d);
        bus.req      = r;
        bus.req_last = l;
        bus.req_data = d;
    endtask

    task automatic do_reset();
        drive(4'b0000, 4'b0000, 32'h0);
        Rst = 1'b1;
        repeat (2) @(negedge Clk_100M);
        Rst = 1'b0;
    endtask

    task automatic wait_ack(input int limit, output int cyc);
        cyc = 0;
        while (bus.req_ack == '0 && cyc < limit) begin
            @(negedge Clk_100M);
            cyc++;
        end
    endtask

    task automatic expect_grant(input string tag, input int id, input logic [7:0] data,
                                input logic lck, input int lat);
        int cyc;
        logic [NUM_REQ-1:0] onehot;
        onehot = NUM_REQ'(1) << id;
        wait_ack(60, cyc);
        if (lat != 0) check({tag, "_ack_latency"}, cyc, lat);
        check({tag, "_ack"}, 32'(bus.req_ack), 32'(onehot));
        check({tag, "_active_id"}, 32'(bus.active_id), 32'(id));
        check({tag, "_locked"}, 32'(bus.locked), 32'(lck));
        @(negedge Clk_100M);
        check({tag, "_ack_width"}, 32'(bus.req_ack), 32'h0);
        check({tag, "_start"}, 32'(bus.tx_start), 32'h1);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'(data));
    endtask

    task automatic wait_frame(input string tag, input logic [7:0] data);
        int cyc;
        cyc = 0;
        while ((bus.tx_busy || tx_cnt != 0) && cyc < 60) begin
            @(negedge Clk_100M);
            cyc++;
        end
        check({tag, "_frame_done"}, 32'(bus.tx_busy), 32'h0);
        check({tag, "_tx_data_stable"}, 32'(bus.tx_data), 32'(data));
    endtask

    initial begin
        int cyc;
        // rst, req, last, data, exp_id, exp_data, exp_locked, exp_lat
        vecs[0] = '{1'b1, 4'b0100, 4'b0100, 32'h0041_0000, 2, 8'h41, 1'b0, 1};
        vecs[1] = '{1'b1, 4'b1111, 4'b1111, 32'h8483_8281, 1, 8'h82, 1'b0, 1};
        vecs[2] = '{1'b0, 4'b1111, 4'b1111, 32'h8483_8281, 2, 8'h83, 1'b0, 0};
        vecs[3] = '{1'b0, 4'b1111, 4'b1111, 32'h8483_8281, 3, 8'h84, 1'b0, 0};
        vecs[4] = '{1'b0, 4'b1111, 4'b1111, 32'h8483_8281, 0, 8'h81, 1'b0, 0};
        vecs[5] = '{1'b0, 4'b1111, 4'b1111, 32'h8483_8281, 1, 8'h82, 1'b0, 0};
        vecs[6] = '{1'b0, 4'b0001, 4'b0000, 32'h0000_00A0, 0, 8'hA0, 1'b1, 0};
        vecs[7] = '{1'b0, 4'b1001, 4'b0000, 32'hD300_00A1, 0, 8'hA1, 1'b1, 0};
        vecs[8] = '{1'b0, 4'b1001, 4'b0001, 32'hD300_00A2, 0, 8'hA2, 1'b0, 0};
        vecs[9] = '{1'b0, 4'b1000, 4'b1000, 32'hD300_0000, 3, 8'hD3, 1'b0, 0};

        tx_en = 1'b1;
        Rst   = 1'b1;
        drive(4'b0000, 4'b0000, 32'h0);
        @(negedge Clk_100M);
        check("rst_req_ack", 32'(bus.req_ack), 32'h0);
        check("rst_tx_start", 32'(bus.tx_start), 32'h0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h0);
        check("rst_active_id", 32'(bus.active_id), 32'h0);
        check("rst_locked", 32'(bus.locked), 32'h0);
        check("rst_timeout_err", 32'(bus.timeout_err), 32'h0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) begin
                do_reset();
                drive(vecs[i].req, vecs[i].last, vecs[i].data);
            end
            expect_grant($sformatf("v%0d", i), vecs[i].exp_id, vecs[i].exp_data,
                         vecs[i].exp_locked, vecs[i].exp_lat);
            if (i + 1 < NV && !vecs[i + 1].rst)
                drive(vecs[i + 1].req, vecs[i + 1].last, vecs[i + 1].data);
            else
                drive(4'b0000, 4'b0000, 32'h0);
            wait_frame($sformatf("v%0d", i), vecs[i].exp_data);
        end

        // Busy never rises: timeout drops the lock and the next request is served.
        do_reset();
        tx_en = 1'b0;
        drive(4'b0001, 4'b0000, 32'h0000_0055);
        expect_grant("tmo", 0, 8'h55, 1'b1, 1);
        drive(4'b0000, 4'b0000, 32'h0);
        cyc = 0;
        while (!bus.timeout_err && cyc < int'(BUSY_TIMEOUT) + 10) begin
            @(negedge Clk_100M);
            cyc++;
        end
        check("tmo_latency", 32'(cyc), 32'(BUSY_TIMEOUT));
        check("tmo_pulse", 32'(bus.timeout_err), 32'h1);
        check("tmo_unlock", 32'(bus.locked), 32'h0);
        tx_en = 1'b1;
        drive(4'b0010, 4'b0010, 32'h0000_6600);
        @(negedge Clk_100M);
        check("tmo_pulse_width", 32'(bus.timeout_err), 32'h0);
        expect_grant("tmo_next", 1, 8'h66, 1'b0, 0);
        drive(4'b0000, 4'b0000, 32'h0);
        wait_frame("tmo_next", 8'h66);

        // Owner stalls mid-message: lock is held LOCK_HOLD idle cycles, then dropped.
        do_reset();
        drive(4'b0010, 4'b0000, 32'h0000_7700);
        expect_grant("hold", 1, 8'h77, 1'b1, 1);
        drive(4'b0100, 4'b0100, 32'h0088_0000);
        wait_frame("hold", 8'h77);
        cyc = 0;
        while (bus.locked && cyc < int'(LOCK_HOLD) + 20) begin
            @(negedge Clk_100M);
            cyc++;
        end
        check("hold_cycles", 32'(cyc), 32'(LOCK_HOLD + 1));
        expect_grant("hold_next", 2, 8'h88, 1'b0, 1);
        drive(4'b0000, 4'b0000, 32'h0);
        wait_frame("hold_next", 8'h88);

        // Asynchronous reset while the transmitter is busy.
        do_reset();
        drive(4'b1000, 4'b0000, 32'h9900_0000);
        expect_grant("arst", 3, 8'h99, 1'b1, 1);
        drive(4'b0000, 4'b0000, 32'h0);
        cyc = 0;
        while (!bus.tx_busy && cyc < 10) begin
            @(negedge Clk_100M);
            cyc++;
        end
        check("arst_busy_seen", 32'(bus.tx_busy), 32'h1);
        #2 Rst = 1'b1;
        #1;
        check("arst_tx_data", 32'(bus.tx_data), 32'h0);
        check("arst_active_id", 32'(bus.active_id), 32'h0);
        check("arst_locked", 32'(bus.locked), 32'h0);
        check("arst_req_ack", 32'(bus.req_ack), 32'h0);
        check("arst_tx_start", 32'(bus.tx_start), 32'h0);
        check("arst_timeout_err", 32'(bus.timeout_err), 32'h0);
        repeat (2) @(negedge Clk_100M);
        Rst = 1'b0;
        drive(4'b1001, 4'b1001, 32'h1300_0010);
        expect_grant("arst_next", 3, 8'h13, 1'b0, 1);
        drive(4'b0000, 4'b0000, 32'h0);
        wait_frame("arst_next", 8'h13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
